// File: rtl/touchscreen_adc_ctrl_if.sv
// Sample handshake between the touch ADC controller and the interface stage.
interface touchscreen_adc_ctrl_if;
  logic        TS_STB;
  logic        TS_ACK;
  logic [11:0] TS_DAT_X;
  logic [11:0] TS_DAT_Y;

  modport master (
    output TS_STB,
    output TS_DAT_X,
    output TS_DAT_Y,
    input  TS_ACK
  );

  modport slave (
    input  TS_STB,
    input  TS_DAT_X,
    input  TS_DAT_Y,
    output TS_ACK
  );
endinterface

// File: rtl/touchscreen_adc_ctrl.sv
// XPT2046/ADS7843-class touch ADC poller: pen-gated, rate-limited X then Y
// 24-clock SPI conversions, a settle/pen re-check, then a STB/ACK handshake.
module touchscreen_adc_ctrl #(
  parameter int unsigned CLK_DIV       = 25,
  parameter int unsigned SAMPLE_PERIOD = 1000000,
  parameter int unsigned SETTLE_CYC    = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic                   TS_SCLK,
  output logic                   TS_CS_N,
  output logic                   TS_MOSI,
  input  logic                   TS_MISO,
  input  logic                   TS_PENIRQ_N,
  touchscreen_adc_ctrl_if.master ts
);

  localparam int unsigned DivW    = $clog2(CLK_DIV);
  localparam int unsigned PerW    = $clog2(SAMPLE_PERIOD);
  localparam int unsigned WaitMax = (2 * CLK_DIV - 1 > SETTLE_CYC) ? 2 * CLK_DIV - 1 : SETTLE_CYC;
  localparam int unsigned WaitW   = $clog2(WaitMax + 1);

  typedef enum logic [2:0] {StIdle, StConvX, StGap, StConvY, StSettle, StOut} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [PerW-1:0]  per_q, per_d;
  logic [WaitW-1:0] wcnt_q, wcnt_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             hi_q, hi_d;
  logic [4:0]       bit_q, bit_d;
  logic [11:0]      cap_q, cap_d;
  logic [11:0]      x_hold_q, x_hold_d;
  logic [11:0]      dat_x_q, dat_x_d;
  logic [11:0]      dat_y_q, dat_y_d;
  logic             stb_q, stb_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;

  logic             pen_dn;
  logic             conv_d;
  logic [7:0]       cmd;

  assign pen_dn = ~sync_q[1];

  // State register and registered SPI/handshake outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= StIdle;
      sync_q   <= 2'b11;
      per_q    <= '0;
      wcnt_q   <= '0;
      div_q    <= '0;
      hi_q     <= 1'b0;
      bit_q    <= '0;
      cap_q    <= '0;
      x_hold_q <= '0;
      dat_x_q  <= '0;
      dat_y_q  <= '0;
      stb_q    <= 1'b0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      per_q    <= per_d;
      wcnt_q   <= wcnt_d;
      div_q    <= div_d;
      hi_q     <= hi_d;
      bit_q    <= bit_d;
      cap_q    <= cap_d;
      x_hold_q <= x_hold_d;
      dat_x_q  <= dat_x_d;
      dat_y_q  <= dat_y_d;
      stb_q    <= stb_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      mosi_q   <= mosi_d;
    end
  end

  // Next-state: sequencing, SCLK phase timing, MISO capture, result load.
  always_comb begin
    state_d  = state_q;
    sync_d   = {sync_q[0], TS_PENIRQ_N};
    per_d    = (per_q == '0) ? '0 : per_q - 1'b1;
    wcnt_d   = wcnt_q;
    div_d    = div_q;
    hi_d     = hi_q;
    bit_d    = bit_q;
    cap_d    = cap_q;
    x_hold_d = x_hold_q;
    dat_x_d  = dat_x_q;
    dat_y_d  = dat_y_q;

    unique case (state_q)
      StIdle: begin
        if (pen_dn && per_q == '0) begin
          state_d = StConvX;
          per_d   = PerW'(SAMPLE_PERIOD - 1);
        end
      end
      StConvX, StConvY: begin
        // Sample in the first high cycle of periods 10..21 (bit index 9..20).
        if (hi_q && div_q == '0 && bit_q >= 5'd9 && bit_q <= 5'd20) begin
          cap_d = {cap_q[10:0], TS_MISO};
        end
        if (div_q == DivW'(CLK_DIV - 1)) begin
          div_d = '0;
          hi_d  = ~hi_q;
          if (hi_q) begin
            if (bit_q == 5'd23) begin
              bit_d  = '0;
              wcnt_d = '0;
              if (state_q == StConvX) begin
                state_d  = StGap;
                x_hold_d = cap_q;
              end else begin
                state_d = StSettle;
              end
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StGap: begin
        if (wcnt_q == WaitW'(2 * CLK_DIV - 1)) begin
          state_d = StConvY;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      StSettle: begin
        // SETTLE_CYC idle cycles, then one cycle that decides on pen_dn.
        if (wcnt_q == WaitW'(SETTLE_CYC)) begin
          wcnt_d = '0;
          if (pen_dn) begin
            state_d = StOut;
            dat_x_d = x_hold_q;
            dat_y_d = cap_q;
          end else begin
            state_d = StIdle;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      StOut: begin
        if (ts.TS_ACK) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are derived from next-state so the registered pins line up with state_q.
    conv_d = (state_d == StConvX) || (state_d == StConvY);
    cmd    = (state_d == StConvY) ? 8'h90 : 8'hD0;
    sclk_d = conv_d && hi_d;
    cs_n_d = ~conv_d;
    mosi_d = conv_d && (bit_d < 5'd8) && cmd[3'd7 - bit_d[2:0]];
    stb_d  = (state_d == StOut);
  end

  assign TS_SCLK     = sclk_q;
  assign TS_CS_N     = cs_n_q;
  assign TS_MOSI     = mosi_q;
  assign ts.TS_STB   = stb_q;
  assign ts.TS_DAT_X = dat_x_q;
  assign ts.TS_DAT_Y = dat_y_q;

endmodule

// File: tb/tb_touchscreen_adc_ctrl.sv
// Bench for touchscreen_adc_ctrl: ADC model on the SPI pins, pin monitor,
// and a directed/randomized sequence checked against timing derived from the rules.
module tb_touchscreen_adc_ctrl;

  localparam int unsigned ClkDiv       = 4;
  localparam int unsigned SamplePeriod = 2000;
  localparam int unsigned SettleCyc    = 16;
  localparam int WinLen  = 48 * ClkDiv;
  localparam int GapLen  = 2 * ClkDiv;
  localparam int Latency = 96 * ClkDiv + 2 * ClkDiv + SettleCyc + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ts_sclk, ts_cs_n, ts_mosi;
  logic ts_miso = 1'b0;
  logic ts_penirq_n = 1'b1;

  touchscreen_adc_ctrl_if ts_if ();

  touchscreen_adc_ctrl #(
    .CLK_DIV      (ClkDiv),
    .SAMPLE_PERIOD(SamplePeriod),
    .SETTLE_CYC   (SettleCyc)
  ) u_dut (
    .CLK        (clk),
    .RST        (rst_n),
    .TS_SCLK    (ts_sclk),
    .TS_CS_N    (ts_cs_n),
    .TS_MOSI    (ts_mosi),
    .TS_MISO    (ts_miso),
    .TS_PENIRQ_N(ts_penirq_n),
    .ts         (ts_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ADC model: shifts the command in on SCLK rise, presents D11..D0 in periods 10..21.
  logic [11:0] x_val = 12'h0;
  logic [11:0] y_val = 12'h0;
  logic [11:0] word;
  logic [7:0]  cmd_sh = 8'h0;
  int          pcnt = 0;
  logic [7:0]  cmd_q[$];

  always @(posedge ts_sclk or posedge ts_cs_n) begin
    if (ts_cs_n) begin
      if (pcnt == 24) cmd_q.push_back(cmd_sh);
      pcnt    = 0;
      cmd_sh  = 8'h0;
      ts_miso = 1'b0;
    end else begin
      pcnt++;
      if (pcnt <= 8) cmd_sh = {cmd_sh[6:0], ts_mosi};
      word    = (cmd_sh == 8'hD0) ? x_val : y_val;
      ts_miso = (pcnt >= 10 && pcnt <= 21) ? word[4'(21 - pcnt)] : 1'b0;
    end
  end

  // Pin monitor: window/gap lengths, STB timing and protocol invariants.
  int cyc = 0;
  int cs_run = 0;
  int hi_run = 0;
  int stb_run = 0;
  int sclk_run = 0;
  int proto_err = 0;
  int cs_fall_q[$];
  int win_len_q[$];
  int gap_q[$];
  int stb_rise_q[$];
  int stb_w_q[$];
  logic        prev_sclk = 1'b0;
  logic        prev_cs_n = 1'b1;
  logic        prev_mosi = 1'b0;
  logic        prev_stb = 1'b0;
  logic [23:0] prev_dat = 24'h0;

  always @(negedge clk) begin
    cyc++;
    if (ts_cs_n === 1'b1 && ts_sclk !== 1'b0) proto_err++;
    if (ts_mosi !== prev_mosi && !(ts_sclk === 1'b0 && (prev_sclk || prev_cs_n))) proto_err++;
    if (ts_if.TS_STB === 1'b1 && ts_cs_n !== 1'b1) proto_err++;
    if (ts_if.TS_STB === 1'b1 && prev_stb && {ts_if.TS_DAT_X, ts_if.TS_DAT_Y} !== prev_dat)
      proto_err++;
    if (ts_sclk === 1'b1) begin
      sclk_run++;
    end else begin
      if (prev_sclk && sclk_run != ClkDiv) proto_err++;
      sclk_run = 0;
    end
    if (ts_cs_n === 1'b0) begin
      if (prev_cs_n) begin
        cs_fall_q.push_back(cyc);
        gap_q.push_back(hi_run);
        cs_run = 0;
      end
      cs_run++;
      hi_run = 0;
    end else begin
      if (!prev_cs_n) win_len_q.push_back(cs_run);
      hi_run++;
    end
    if (ts_if.TS_STB === 1'b1) begin
      if (!prev_stb) begin
        stb_rise_q.push_back(cyc);
        stb_run = 0;
      end
      stb_run++;
    end else if (prev_stb) begin
      stb_w_q.push_back(stb_run);
    end
    prev_sclk = (ts_sclk === 1'b1);
    prev_cs_n = (ts_cs_n !== 1'b0);
    prev_mosi = ts_mosi;
    prev_stb  = (ts_if.TS_STB === 1'b1);
    prev_dat  = {ts_if.TS_DAT_X, ts_if.TS_DAT_Y};
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_queues();
    cmd_q.delete();
    cs_fall_q.delete();
    win_len_q.delete();
    gap_q.delete();
    stb_rise_q.delete();
    stb_w_q.delete();
  endtask

  logic [11:0] exp_x = 12'h0;
  logic [11:0] exp_y = 12'h0;
  int          last_fall = -1;

  task automatic new_vals(input bit expect_out);
    x_val = 12'($urandom_range(0, 4095));
    y_val = 12'($urandom_range(0, 4095));
    if (expect_out) begin
      exp_x = x_val;
      exp_y = y_val;
    end
  endtask

  // One full sample: wait for STB, handshake, then check timing/commands from the monitor.
  task automatic do_sample(input int unsigned ack_dly, input bit ack_early);
    int unsigned n;
    int x_fall, y_fall;
    if (ack_early) ts_if.TS_ACK = 1'b1;
    n = 0;
    while (ts_if.TS_STB !== 1'b1 && n < 4000) begin
      step();
      n++;
    end
    check("stb_seen", ts_if.TS_STB, 1'b1);
    if (ts_if.TS_STB !== 1'b1) begin
      ts_if.TS_ACK = 1'b0;
      return;
    end
    if (!ack_early) begin
      repeat (ack_dly) step();
      ts_if.TS_ACK = 1'b1;
    end
    step();
    ts_if.TS_ACK = 1'b0;
    check("stb_drop", ts_if.TS_STB, 1'b0);
    check("dat_x", ts_if.TS_DAT_X, exp_x);
    check("dat_y", ts_if.TS_DAT_Y, exp_y);
    check("stb_width", (stb_w_q.size() > 0) ? stb_w_q.pop_front() : -1,
          ack_early ? 1 : ack_dly + 1);
    check("n_windows", cs_fall_q.size(), 2);
    check("n_cmds", cmd_q.size(), 2);
    if (cs_fall_q.size() >= 2 && cmd_q.size() >= 2 && win_len_q.size() >= 2 &&
        gap_q.size() >= 2 && stb_rise_q.size() >= 1) begin
      x_fall = cs_fall_q.pop_front();
      y_fall = cs_fall_q.pop_front();
      check("cmd_x", cmd_q.pop_front(), 8'hD0);
      check("cmd_y", cmd_q.pop_front(), 8'h90);
      check("win_x_len", win_len_q.pop_front(), WinLen);
      check("win_y_len", win_len_q.pop_front(), WinLen);
      void'(gap_q.pop_front());
      check("gap_len", gap_q.pop_front(), GapLen);
      check("x_to_y", y_fall - x_fall, WinLen + GapLen);
      check("latency", stb_rise_q.pop_front() - x_fall, Latency);
      if (last_fall >= 0) check("rate", x_fall - last_fall, SamplePeriod);
      last_fall = x_fall;
    end
  endtask

  initial begin
    int unsigned n;
    ts_if.TS_ACK = 1'b0;
    rst_n = 1'b0;
    ts_penirq_n = 1'b1;
    repeat (3) step();
    check("rst_cs_n", ts_cs_n, 1'b1);
    check("rst_sclk", ts_sclk, 1'b0);
    check("rst_mosi", ts_mosi, 1'b0);
    check("rst_stb", ts_if.TS_STB, 1'b0);
    check("rst_dat_x", ts_if.TS_DAT_X, 12'h0);
    check("rst_dat_y", ts_if.TS_DAT_Y, 12'h0);
    rst_n = 1'b1;
    repeat (5) step();
    check("idle_no_pen", ts_cs_n, 1'b1);
    clear_queues();

    // First touch: CS falls on the third edge after PENIRQ_N drops.
    new_vals(1'b1);
    ts_penirq_n = 1'b0;
    repeat (2) step();
    check("start_early", ts_cs_n, 1'b1);
    step();
    check("start_delay", ts_cs_n, 1'b0);
    do_sample(5, 1'b0);

    // Pen held down: back-to-back samples at the rate limit, random ACK delays.
    for (int i = 0; i < 5; i++) begin
      new_vals(1'b1);
      do_sample($urandom_range(0, 7), (i == 2));
    end

    // Pen released during the Y conversion: result discarded, bus goes quiet.
    new_vals(1'b0);
    n = 0;
    while (cs_fall_q.size() < 2 && n < 5000) begin
      step();
      n++;
    end
    check("rel_y_start", cs_fall_q.size(), 2);
    repeat (10) step();
    ts_penirq_n = 1'b1;
    repeat (3000) step();
    check("rel_no_stb", stb_rise_q.size(), 0);
    check("rel_stb_low", ts_if.TS_STB, 1'b0);
    check("rel_keep_x", ts_if.TS_DAT_X, exp_x);
    check("rel_keep_y", ts_if.TS_DAT_Y, exp_y);
    check("rel_no_spi", cs_fall_q.size(), 2);
    check("rel_cs_idle", ts_cs_n, 1'b1);
    clear_queues();

    // Reset in period 12 of the X conversion, then a clean restart.
    new_vals(1'b1);
    ts_penirq_n = 1'b0;
    n = 0;
    while (cs_fall_q.size() < 1 && n < 100) begin
      step();
      n++;
    end
    check("mid_x_start", cs_fall_q.size(), 1);
    repeat (90) step();
    rst_n = 1'b0;
    step();
    check("mid_rst_cs_n", ts_cs_n, 1'b1);
    check("mid_rst_sclk", ts_sclk, 1'b0);
    check("mid_rst_mosi", ts_mosi, 1'b0);
    check("mid_rst_stb", ts_if.TS_STB, 1'b0);
    check("mid_rst_dat_x", ts_if.TS_DAT_X, 12'h0);
    check("mid_rst_dat_y", ts_if.TS_DAT_Y, 12'h0);
    step();
    rst_n = 1'b1;
    clear_queues();
    last_fall = -1;
    do_sample($urandom_range(0, 7), 1'b0);

    ts_penirq_n = 1'b1;
    repeat (10) step();
    check("protocol", proto_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
